pll_reset_ctrl: RTL



---
 rtl/pll_ctrl_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_reset_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: state encoding and shared widths for the PLL reset controller
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int RELOCK_W = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with async active-low reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: sequences PLL reset, lock qualification, system reset release and recovery
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                req_relock,
  output logic                pll_rst,
  output logic                sys_reset_n,
  output logic                lock_fail,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [2:0]          state_o
);

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  // the WAIT_LOCK cycle that first sees lock counts as one of the stable cycles
  localparam logic [SW-1:0] STAB_LAST  = SW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);

  logic                locked_s;
  pll_state_e          state_q, state_d;
  logic [PW-1:0]       pulse_q, pulse_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_rst_q, sys_q, fail_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // next-state and counter updates; counters not owned by the current state fall to zero
  always_comb begin
    state_d  = state_q;
    pulse_d  = '0;
    tmo_d    = '0;
    stab_d   = '0;
    retry_d  = retry_q;
    relock_d = relock_q;
    case (state_q)
      ST_RESET_PLL: begin
        pulse_d = pulse_q + 1'b1;
        if (pulse_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          pulse_d = '0;
        end
      end
      ST_WAIT_LOCK: begin
        tmo_d = tmo_q;
        if (req_relock) begin
          state_d = ST_RESET_PLL;
          tmo_d   = '0;
        end else if (locked_s) begin
          state_d = ST_STABLE;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RESET_PLL;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_STABLE: begin
        tmo_d  = tmo_q;
        stab_d = stab_q + 1'b1;
        if (req_relock) begin
          state_d = ST_RESET_PLL;
          tmo_d   = '0;
          stab_d  = '0;
        end else if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
          stab_d  = '0;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d  = ST_RESET_PLL;
          relock_d = (relock_q == RELOCK_MAX) ? relock_q : relock_q + 1'b1;
        end else if (req_relock) begin
          state_d = ST_RESET_PLL;
        end
      end
      ST_FAULT: begin
        if (req_relock) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase
  end

  // state, counters and registered outputs decoded from the next state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET_PLL;
      pulse_q   <= '0;
      tmo_q     <= '0;
      stab_q    <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      sys_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      tmo_q     <= tmo_d;
      stab_q    <= stab_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_rst_q <= (state_d == ST_RESET_PLL);
      sys_q     <= (state_d == ST_RUN);
      fail_q    <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_reset_n  = sys_q;
  assign lock_fail    = fail_q;
  assign relock_count = relock_q;
  assign state_o      = state_q;

endmodule
